// File: rtl/sort_pkg.sv
// Shared types for the sort_stream_ctrl slice: command selects, Gray-coded FSM states, defaults.
package sort_pkg;

    localparam int DW_DEF    = 16;
    localparam int MAX_N_DEF = 255;

    typedef enum logic [1:0] {
        CMD_CLR  = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_SORT = 2'd2,
        CMD_POP  = 2'd3
    } cmd_t;

    // Stream-side states; the _HI/_LO phases live inside sort_cmd_pulse
    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0000,
        ST_CLR       = 4'b0001,
        ST_LOAD      = 4'b0011,
        ST_PUSH      = 4'b0010,
        ST_DRAIN     = 4'b0110,
        ST_SORT      = 4'b0111,
        ST_SORT_WAIT = 4'b0101,
        ST_POP       = 4'b0100,
        ST_OUT       = 4'b1100
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_HI   = 2'b01,
        PH_LO   = 2'b11
    } phase_t;

endpackage

// File: rtl/sort_cmd_pulse.sv
// Command pin sequencer: PULSE_W high, GAP_W low, then poll srt_idle before signalling done.
// With SORT_STREAM_CTRL_TIMEOUT_EN, exposes the idle-wait phase and accepts an abort.
module sort_cmd_pulse
    import sort_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic start,
    input  cmd_t sel,
    input  logic srt_idle,
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
    input  logic abort,
    output logic waiting,
`endif
    output logic clr,
    output logic push,
    output logic sort,
    output logic pop,
    output logic done
);

    phase_t     r_phase;
    logic [7:0] r_cnt;
    logic       r_clr, r_push, r_sort, r_pop, r_done;
    logic       w_gap_end;

    assign w_gap_end = (r_cnt == 8'(GAP_W - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_clr   <= 1'b0;
            r_push  <= 1'b0;
            r_sort  <= 1'b0;
            r_pop   <= 1'b0;
            r_done  <= 1'b0;
        end else if (enable) begin
            r_done <= 1'b0;
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
            if (abort) begin
                r_phase <= PH_IDLE;
                r_cnt   <= '0;
                r_clr   <= 1'b0;
                r_push  <= 1'b0;
                r_sort  <= 1'b0;
                r_pop   <= 1'b0;
            end else
`endif
            begin
                case (r_phase)
                    PH_IDLE: if (start) begin
                        r_phase <= PH_HI;
                        r_cnt   <= '0;
                        r_clr   <= (sel == CMD_CLR);
                        r_push  <= (sel == CMD_PUSH);
                        r_sort  <= (sel == CMD_SORT);
                        r_pop   <= (sel == CMD_POP);
                    end
                    PH_HI: if (r_cnt == 8'(PULSE_W - 1)) begin
                        r_phase <= PH_LO;
                        r_cnt   <= '0;
                        r_clr   <= 1'b0;
                        r_push  <= 1'b0;
                        r_sort  <= 1'b0;
                        r_pop   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    PH_LO: if (!w_gap_end) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else if (srt_idle) begin
                        r_phase <= PH_IDLE;
                        r_done  <= 1'b1;
                    end
                    default: r_phase <= PH_IDLE;
                endcase
            end
        end
    end

    assign clr  = r_clr;
    assign push = r_push;
    assign sort = r_sort;
    assign pop  = r_pop;
    assign done = r_done;
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
    assign waiting = (r_phase == PH_LO) && w_gap_end && !srt_idle;
`endif

endmodule

// File: rtl/sort_stream_ctrl.sv
// Stream adapter: frames in -> clear/push/sort on insertion_sort -> pops out, largest first.
// Optional watchdog and err port under SORT_STREAM_CTRL_TIMEOUT_EN.
module sort_stream_ctrl
    import sort_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int MAX_N   = MAX_N_DEF,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          srt_push,
    output logic          srt_pop,
    output logic          srt_clear,
    output logic          srt_sort,
    output logic [DW-1:0] srt_din,
    input  logic [DW-1:0] srt_dout,
    input  logic          srt_full,
    input  logic          srt_empty,
    input  logic          srt_idle,
    output logic          busy,
    output logic          ovf
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
   ,output logic          err
`endif
);

    state_t        r_state;
    cmd_t          r_sel;
    logic          r_start;
    logic [7:0]    r_n, r_k;
    logic          r_last_seen, r_s_ready, r_m_valid, r_m_last, r_ovf;
    logic [DW-1:0] r_din, r_m_data;
    logic          w_done, w_full;

    assign w_full = (r_n == 8'(MAX_N)) || srt_full;

`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
    logic [11:0] r_wd;
    logic        r_err, w_cmd_wait, w_wait, w_wd_fire;

    assign w_wait    = w_cmd_wait || ((r_state == ST_SORT_WAIT) && !srt_idle);
    assign w_wd_fire = w_wait && (r_wd == 12'(TIMEOUT - 1));
    assign err       = r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       r_wd <= '0;
        else if (enable) r_wd <= w_wait ? r_wd + 12'd1 : '0;
    end
`endif

    sort_cmd_pulse #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) u_cmd (
        .clk      (clk),
        .rstn     (rstn),
        .enable   (enable),
        .start    (r_start),
        .sel      (r_sel),
        .srt_idle (srt_idle),
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
        .abort    (w_wd_fire),
        .waiting  (w_cmd_wait),
`endif
        .clr      (srt_clear),
        .push     (srt_push),
        .sort     (srt_sort),
        .pop      (srt_pop),
        .done     (w_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_sel       <= CMD_CLR;
            r_start     <= 1'b0;
            r_n         <= '0;
            r_k         <= '0;
            r_last_seen <= 1'b0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_ovf       <= 1'b0;
            r_din       <= '0;
            r_m_data    <= '0;
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else if (enable) begin
            r_start <= 1'b0;
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
            if (w_wd_fire) begin
                r_err     <= 1'b1;
                r_state   <= ST_IDLE;
                r_s_ready <= 1'b0;
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end else
`endif
            begin
                case (r_state)
                    ST_IDLE: begin
                        r_n <= '0;
                        r_k <= '0;
                        if (s_valid) begin
                            r_ovf   <= 1'b0;
                            r_start <= 1'b1;
                            r_sel   <= CMD_CLR;
                            r_state <= ST_CLR;
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
                            r_err   <= 1'b0;
`endif
                        end
                    end
                    ST_CLR: if (w_done) r_state <= ST_LOAD;
                    ST_LOAD: if (!r_s_ready) begin
                        r_s_ready <= 1'b1;
                    end else if (s_valid) begin
                        r_s_ready   <= 1'b0;
                        r_din       <= s_data;
                        r_n         <= r_n + 8'd1;
                        r_last_seen <= s_last;
                        r_start     <= 1'b1;
                        r_sel       <= CMD_PUSH;
                        r_state     <= ST_PUSH;
                    end
                    ST_PUSH: if (w_done) begin
                        if (r_last_seen) begin
                            r_start <= 1'b1;
                            r_sel   <= CMD_SORT;
                            r_state <= ST_SORT;
                        end else if (w_full) begin
                            r_ovf   <= 1'b1;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                    // Surplus words are accepted and dropped until the frame's last word
                    ST_DRAIN: if (!r_s_ready) begin
                        r_s_ready <= 1'b1;
                    end else if (s_valid && s_last) begin
                        r_s_ready <= 1'b0;
                        r_start   <= 1'b1;
                        r_sel     <= CMD_SORT;
                        r_state   <= ST_SORT;
                    end
                    ST_SORT: if (w_done) r_state <= ST_SORT_WAIT;
                    ST_SORT_WAIT: if (srt_idle) begin
                        r_k     <= '0;
                        r_start <= 1'b1;
                        r_sel   <= CMD_POP;
                        r_state <= ST_POP;
                    end
                    ST_POP: if (w_done) begin
                        r_m_data  <= srt_dout;
                        r_k       <= r_k + 8'd1;
                        r_m_last  <= ((r_k + 8'd1) == r_n) || srt_empty;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_OUT;
                    end
                    ST_OUT: if (m_ready) begin
                        r_m_valid <= 1'b0;
                        if (r_m_last) begin
                            r_m_last <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_start <= 1'b1;
                            r_sel   <= CMD_POP;
                            r_state <= ST_POP;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign srt_din = r_din;
    assign busy    = (r_state != ST_IDLE);
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: behavioural sorter, descending-order reference queue, directed frames.
module tb_sort_stream_ctrl;

    logic        clk = 1'b0;
    logic        rstn, enable;
    logic        s_valid, s_ready, s_last;
    logic [15:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [15:0] m_data;
    logic        srt_push, srt_pop, srt_clear, srt_sort;
    logic [15:0] srt_din, srt_dout;
    logic        srt_full, srt_empty, srt_idle;
    logic        busy, ovf;
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    sort_stream_ctrl #(.DW(16), .MAX_N(255), .PULSE_W(2), .GAP_W(3), .TIMEOUT(4096)) dut (
        .clk(clk), .rstn(rstn), .enable(enable),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .srt_push(srt_push), .srt_pop(srt_pop), .srt_clear(srt_clear), .srt_sort(srt_sort),
        .srt_din(srt_din), .srt_dout(srt_dout), .srt_full(srt_full), .srt_empty(srt_empty),
        .srt_idle(srt_idle), .busy(busy), .ovf(ovf)
`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
       ,.err(err)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural sorter: edge-triggered commands, pop returns the current maximum
    logic [15:0] sq[$];
    logic [3:0]  p1, p2, cmd;
    int          bsy, mi;
    logic        hold_busy = 1'b0;
    int          n_clr = 0, n_push = 0, n_sort = 0, n_pop = 0;

    assign srt_idle = (bsy == 0) && !hold_busy;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sq.delete();
            p1 <= '0; p2 <= '0; cmd <= '0; bsy <= 0;
            srt_dout <= '0; srt_full <= 1'b0; srt_empty <= 1'b1;
        end else if (enable) begin
            p1 <= {srt_clear, srt_push, srt_sort, srt_pop};
            p2 <= p1;
            if (bsy > 0) begin
                bsy <= bsy - 1;
                if (bsy == 1) begin
                    if (cmd[3]) sq.delete();
                    if (cmd[2]) sq.push_back(srt_din);
                    if (cmd[0] && sq.size() > 0) begin
                        mi = 0;
                        for (int i = 1; i < sq.size(); i++) if (sq[i] > sq[mi]) mi = i;
                        srt_dout <= sq[mi];
                        sq.delete(mi);
                    end
                    srt_full  <= (sq.size() == 255);
                    srt_empty <= (sq.size() == 0);
                end
            end else if ((p1 & ~p2) != 4'b0) begin
                cmd <= p1 & ~p2;
                bsy <= p1[1] ? 8 : 1;
                if (p1[3] & ~p2[3]) n_clr  <= n_clr + 1;
                if (p1[2] & ~p2[2]) n_push <= n_push + 1;
                if (p1[1] & ~p2[1]) n_sort <= n_sort + 1;
                if (p1[0] & ~p2[0]) n_pop  <= n_pop + 1;
            end
        end
    end

    // Reference: expected output words/last flags; checked every cycle m_valid is up
    logic [15:0] exp_d[$];
    logic        exp_l[$];
    logic [15:0] out_log[$];
    logic        last_log[$];
    logic        prev_hold = 1'b0;

    always @(negedge clk) begin
        if (rstn) begin
            if (prev_hold) chk("valid_hold", m_valid, 1);
            if (m_valid) begin
                if (exp_d.size() == 0) begin
                    chk("spurious_out", m_valid, 0);
                end else begin
                    chk("m_data", m_data, exp_d[0]);
                    chk("m_last", m_last, exp_l[0]);
                    if (m_ready && enable) begin
                        out_log.push_back(m_data);
                        last_log.push_back(m_last);
                        void'(exp_d.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
            prev_hold = m_valid && !(m_ready && enable);
        end else begin
            prev_hold = 1'b0;
        end
    end

    logic [15:0] frame_w [0:299];

    task automatic run_frame(input int L);
        int acc, t, p0, q0, c0, s0;
        logic [15:0] srt[$];
        acc = (L > 255) ? 255 : L;
        srt.delete();
        for (int i = 0; i < acc; i++) begin
            int j = 0;
            while (j < srt.size() && srt[j] >= frame_w[i]) j++;
            srt.insert(j, frame_w[i]);
        end
        for (int i = 0; i < acc; i++) begin
            exp_d.push_back(srt[i]);
            exp_l.push_back(i == acc - 1);
        end
        out_log.delete();
        last_log.delete();
        p0 = n_push; q0 = n_pop; c0 = n_clr; s0 = n_sort;
        for (int i = 0; i < L; i++) begin
            s_valid = 1'b1;
            s_data  = frame_w[i];
            s_last  = (i == L - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (s_ready && enable) break;
                t++;
                if (t > 3000) break;
            end
            if (t > 3000) begin
                chk("in_handshake_timeout", t, 0);
                s_valid = 1'b0;
                exp_d.delete();
                exp_l.delete();
                return;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        t = 0;
        while ((busy || exp_d.size() != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_done_busy", busy, 0);
        chk("pending_outputs", exp_d.size(), 0);
        chk("push_count", n_push - p0, acc);
        chk("pop_count", n_pop - q0, acc);
        chk("clr_count", n_clr - c0, 1);
        chk("sort_count", n_sort - s0, 1);
        chk("ovf", ovf, (L > 255));
        exp_d.delete();
        exp_l.delete();
    endtask

    int tw, qp;

    initial begin
        rstn = 1'b0; enable = 1'b1; m_ready = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_pins", {srt_clear, srt_push, srt_sort, srt_pop}, 0);
        chk("rst_din", srt_din, 0);
        @(posedge clk); #1 rstn = 1'b1;

        // 3,1,2 -> 3,2,1
        frame_w[0] = 16'd3; frame_w[1] = 16'd1; frame_w[2] = 16'd2;
        run_frame(3);
        chk("A_count", out_log.size(), 3);
        chk("A_out0", out_log[0], 16'd3);
        chk("A_out1", out_log[1], 16'd2);
        chk("A_out2", out_log[2], 16'd1);
        chk("A_lasts", {last_log[0], last_log[1], last_log[2]}, 3'b001);

        // one-word frame
        frame_w[0] = 16'h00AA;
        run_frame(1);
        chk("B_count", out_log.size(), 1);
        chk("B_out0", out_log[0], 16'h00AA);
        chk("B_last", last_log[0], 1);
        chk("B_busy", busy, 0);

        // output back-pressure for 10 cycles
        frame_w[0] = 16'd5; frame_w[1] = 16'd9; frame_w[2] = 16'd7;
        m_ready = 1'b0;
        fork
            run_frame(3);
            begin
                tw = 0;
                while (!m_valid && tw < 3000) begin @(negedge clk); tw++; end
                qp = n_pop;
                repeat (10) begin @(negedge clk); chk("stall_valid", m_valid, 1); end
                chk("stall_no_pop", n_pop - qp, 0);
                @(posedge clk); #1 m_ready = 1'b1;
            end
        join
        chk("C_out0", out_log[0], 16'd9);

        // enable frozen during the first push pulse
        frame_w[0] = 16'h1234; frame_w[1] = 16'h0010; frame_w[2] = 16'hFFFF; frame_w[3] = 16'h8000;
        fork
            run_frame(4);
            begin
                tw = 0;
                do begin @(posedge clk); #1; tw++; end while (!srt_push && tw < 3000);
                enable = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("frz_push", srt_push, 1);
                    chk("frz_busy", busy, 1);
                    chk("frz_s_ready", s_ready, 0);
                end
                @(posedge clk); #1 enable = 1'b1;
            end
        join
        chk("D_out0", out_log[0], 16'hFFFF);
        chk("D_out3", out_log[3], 16'h0010);

        // 257 words: 0..256, only 0..254 kept
        for (int i = 0; i < 257; i++) frame_w[i] = 16'(i);
        run_frame(257);
        chk("E_count", out_log.size(), 255);
        chk("E_first", out_log[0], 16'd254);
        chk("E_final", out_log[254], 16'd0);
        chk("E_ovf_sticky", ovf, 1);

        // asynchronous reset while waiting in LOAD
        s_valid = 1'b1; s_data = 16'd5; s_last = 1'b0;
        tw = 0;
        while (!s_ready && tw < 3000) begin @(negedge clk); tw++; end
        chk("G_reached_load", s_ready, 1);
        #2 rstn = 1'b0;
        #1;
        chk("G_async_busy", busy, 0);
        chk("G_async_ready", s_ready, 0);
        s_valid = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;

        frame_w[0] = 16'd7; frame_w[1] = 16'd2; frame_w[2] = 16'd7;
        run_frame(3);
        chk("H_out0", out_log[0], 16'd7);
        chk("H_out2", out_log[2], 16'd2);
        chk("H_ovf_cleared", ovf, 0);

`ifdef SORT_STREAM_CTRL_TIMEOUT_EN
        hold_busy = 1'b1;
        s_valid = 1'b1; s_data = 16'd1; s_last = 1'b1;
        tw = 0;
        while (!busy && tw < 100) begin @(negedge clk); tw++; end
        @(posedge clk); #1 s_valid = 1'b0;
        chk("wd_err_low", err, 0);
        tw = 0;
        while (!err && tw < 6000) begin @(negedge clk); tw++; end
        chk("wd_err", err, 1);
        chk("wd_idle", busy, 0);
        chk("wd_pins", {srt_clear, srt_push, srt_sort, srt_pop}, 0);
        chk("wd_latency", (tw >= 4090) && (tw <= 4120), 1);
        hold_busy = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
